led_code_monitor: RTL and testbench

LED_CODE_MONITOR -- requirements
Module: led_code_monitor

---
 rtl/led_code_monitor.sv | 146 ++++++++++++++
 tb/tb_led_code_monitor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_monitor.sv
// Colour-code LED monitor: synchronizes and debounces four LED drive lines, decodes a 4-bit code,
// checks that successive codes step by +1, and measures the seconds between code changes.
module led_code_monitor #(
    parameter int CLK_HZ        = 125_000_000,
    parameter int STABLE_CYCLES = 16,
    parameter int STEP_SECONDS  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       red1,
    input  logic       blue1,
    input  logic       red2,
    input  logic       blue2,
    input  logic       clr_err,
    output logic [3:0] code,
    output logic       code_valid,
    output logic       seq_err,
    output logic [7:0] err_count,
    output logic [7:0] interval_sec,
    output logic       timeout,
    output logic [1:0] state_dbg
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [PW-1:0] PRE_MAX    = PW'(CLK_HZ - 1);
    localparam logic [7:0]    STALL_SEC  = 8'(STEP_SECONDS + 2);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1, sync2;
    logic [3:0]      candidate;
    logic [CW-1:0]   stable_cnt;
    logic [PW-1:0]   prescaler;
    logic [7:0]      sec_cnt, sec_next;
    logic            pre_wrap;
    logic            accept;
    logic            check_seq;
    logic            seq_bad;

    // Each pair (red,blue) decodes to {blue,red}, so the code is a plain concatenation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 4'd0;
            sync2 <= 4'd0;
        end else begin
            sync1 <= {blue1, red1, blue2, red2};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate  <= 4'd0;
            stable_cnt <= '0;
        end else if (candidate != sync2) begin
            candidate  <= sync2;
            stable_cnt <= '0;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    assign accept = (stable_cnt == STABLE_MAX) && (candidate != code);

    // sec_next includes a wrap landing on this edge, so an accept exactly N seconds apart reports N.
    assign pre_wrap = (prescaler == PRE_MAX);
    assign sec_next = (pre_wrap && sec_cnt != 8'hFF) ? sec_cnt + 8'd1 : sec_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            sec_cnt   <= 8'd0;
        end else if (accept) begin
            prescaler <= '0;
            sec_cnt   <= 8'd0;
        end else begin
            prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
            sec_cnt   <= sec_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        check_seq = 1'b0;
        case (state_q)
            INIT: begin
                if (accept) state_d = TRACK;
            end
            TRACK: begin
                if (accept)                    check_seq = 1'b1;
                else if (sec_cnt >= STALL_SEC) state_d   = STALL;
            end
            STALL: begin
                if (accept) begin
                    check_seq = 1'b1;
                    state_d   = TRACK;
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign seq_bad   = check_seq && (candidate != code + 4'd1);
    assign timeout   = (state_q == STALL);
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code         <= 4'd0;
            code_valid   <= 1'b0;
            interval_sec <= 8'd0;
        end else begin
            code_valid <= accept;
            if (accept) code <= candidate;
            if (accept && state_q != INIT) interval_sec <= sec_next;
        end
    end

    // A new error wins over a coincident clear, leaving a count of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err   <= 1'b0;
            err_count <= 8'd0;
        end else if (seq_bad) begin
            seq_err   <= 1'b1;
            if (clr_err)                err_count <= 8'd1;
            else if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else if (clr_err) begin
            seq_err   <= 1'b0;
            err_count <= 8'd0;
        end
    end

endmodule

// File: tb/tb_led_code_monitor.sv
// Directed bench for led_code_monitor with CLK_HZ=10, STABLE_CYCLES=4, STEP_SECONDS=3.
module tb_led_code_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       red1, blue1, red2, blue2;
    logic       clr_err;
    logic [3:0] code;
    logic       code_valid;
    logic       seq_err;
    logic [7:0] err_count;
    logic [7:0] interval_sec;
    logic       timeout;
    logic [1:0] state_dbg;

    int compared   = 0;
    int mismatched = 0;
    int valid_total;

    led_code_monitor #(
        .CLK_HZ(10),
        .STABLE_CYCLES(4),
        .STEP_SECONDS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .red1(red1),
        .blue1(blue1),
        .red2(red2),
        .blue2(blue2),
        .clr_err(clr_err),
        .code(code),
        .code_valid(code_valid),
        .seq_err(seq_err),
        .err_count(err_count),
        .interval_sec(interval_sec),
        .timeout(timeout),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // code = {blue1, red1, blue2, red2}
    task automatic set_pattern(input logic [3:0] p);
        blue1 = p[3];
        red1  = p[2];
        blue2 = p[1];
        red2  = p[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr_err = 1'b0;
        set_pattern(4'd0);
        repeat (3) tick();
        compared++;
        if ({code, code_valid, seq_err, err_count, interval_sec, timeout, state_dbg} !== 27'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got code=%0d v=%0d err=%0d cnt=%0d int=%0d to=%0d st=%0d, expected all 0",
                     code, code_valid, seq_err, err_count, interval_sec, timeout, state_dbg);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_code();
        valid_total = 0;
        set_pattern(4'd1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (code_valid) valid_total++;
            compared++;
            if (code_valid !== (k == 7)) begin
                mismatched++;
                $display("FAIL first_latency edge %0d: code_valid=%0b expected %0b", k, code_valid, k == 7);
            end
        end
        compared++;
        if (code !== 4'd1 || seq_err !== 1'b0 || interval_sec !== 8'd0 || state_dbg !== 2'd1) begin
            mismatched++;
            $display("FAIL first_code: code=%0d err=%0b int=%0d st=%0d, expected 1 0 0 1",
                     code, seq_err, interval_sec, state_dbg);
        end
    endtask

    task automatic test_sequence();
        for (int v = 2; v <= 16; v++) begin
            set_pattern(4'(v));
            for (int k = 1; k <= 30; k++) begin
                tick();
                if (code_valid) valid_total++;
                compared++;
                if (code_valid !== (k == 7)) begin
                    mismatched++;
                    $display("FAIL seq_valid v=%0d edge %0d: code_valid=%0b expected %0b", v, k, code_valid, k == 7);
                end
            end
            compared++;
            if (code !== 4'(v) || seq_err !== 1'b0 || interval_sec !== 8'd3 || timeout !== 1'b0) begin
                mismatched++;
                $display("FAIL seq_step v=%0d: code=%0d err=%0b int=%0d to=%0b, expected %0d 0 3 0",
                         v, code, seq_err, interval_sec, timeout, v % 16);
            end
        end
        compared++;
        if (valid_total !== 16) begin
            mismatched++;
            $display("FAIL seq_pulse_count: got %0d pulses, expected 16", valid_total);
        end
    endtask

    task automatic test_glitch();
        for (int v = 1; v <= 2; v++) begin
            set_pattern(4'(v));
            repeat (30) tick();
        end
        compared++;
        if (code !== 4'd2 || seq_err !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_setup: code=%0d err=%0b, expected 2 0", code, seq_err);
        end
        set_pattern(4'd5);
        repeat (3) tick();
        set_pattern(4'd2);
        valid_total = 0;
        repeat (10) begin
            tick();
            if (code_valid) valid_total++;
        end
        compared++;
        if (valid_total !== 0 || code !== 4'd2) begin
            mismatched++;
            $display("FAIL glitch: pulses=%0d code=%0d, expected 0 pulses, code 2", valid_total, code);
        end
    endtask

    task automatic test_seq_err();
        for (int v = 3; v <= 4; v++) begin
            set_pattern(4'(v));
            repeat (30) tick();
        end
        compared++;
        if (code !== 4'd4 || seq_err !== 1'b0) begin
            mismatched++;
            $display("FAIL err_setup: code=%0d err=%0b, expected 4 0", code, seq_err);
        end
        set_pattern(4'd7);
        repeat (30) tick();
        compared++;
        if (code !== 4'd7 || seq_err !== 1'b1 || err_count !== 8'd1) begin
            mismatched++;
            $display("FAIL err_detect: code=%0d err=%0b cnt=%0d, expected 7 1 1", code, seq_err, err_count);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        compared++;
        if (seq_err !== 1'b0 || err_count !== 8'd0) begin
            mismatched++;
            $display("FAIL err_clear: err=%0b cnt=%0d, expected 0 0", seq_err, err_count);
        end
        set_pattern(4'd9);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 7) begin
                clr_err = 1'b0;
                compared++;
                if (code_valid !== 1'b1 || seq_err !== 1'b1 || err_count !== 8'd1) begin
                    mismatched++;
                    $display("FAIL err_clr_coincident: v=%0b err=%0b cnt=%0d, expected 1 1 1",
                             code_valid, seq_err, err_count);
                end
            end
            if (k == 6) clr_err = 1'b1;
        end
    endtask

    task automatic test_timeout();
        set_pattern(4'd6);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 7) begin
                compared++;
                if (code_valid !== 1'b1 || code !== 4'd6 || err_count !== 8'd2) begin
                    mismatched++;
                    $display("FAIL to_accept6: v=%0b code=%0d cnt=%0d, expected 1 6 2", code_valid, code, err_count);
                end
            end
            if (k == 10) clr_err = 1'b1;
            if (k == 11) begin
                clr_err = 1'b0;
                compared++;
                if (seq_err !== 1'b0 || err_count !== 8'd0) begin
                    mismatched++;
                    $display("FAIL to_clear: err=%0b cnt=%0d, expected 0 0", seq_err, err_count);
                end
            end
            if (k == 56) begin
                compared++;
                if (timeout !== 1'b0 || state_dbg !== 2'd1) begin
                    mismatched++;
                    $display("FAIL to_early: to=%0b st=%0d, expected 0 1", timeout, state_dbg);
                end
            end
        end
        compared++;
        if (timeout !== 1'b1 || state_dbg !== 2'd2) begin
            mismatched++;
            $display("FAIL to_stall: to=%0b st=%0d, expected 1 2", timeout, state_dbg);
        end
        set_pattern(4'd7);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 6) begin
                compared++;
                if (timeout !== 1'b1) begin
                    mismatched++;
                    $display("FAIL to_hold: to=%0b expected 1", timeout);
                end
            end
            if (k == 7) begin
                compared++;
                if (code_valid !== 1'b1 || timeout !== 1'b0 || code !== 4'd7 || seq_err !== 1'b0 ||
                    interval_sec !== 8'd6 || state_dbg !== 2'd1) begin
                    mismatched++;
                    $display("FAIL to_recover: v=%0b to=%0b code=%0d err=%0b int=%0d st=%0d, expected 1 0 7 0 6 1",
                             code_valid, timeout, code, seq_err, interval_sec, state_dbg);
                end
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        set_pattern(4'd8);
        repeat (4) tick();
        rst = 1'b1;
        set_pattern(4'd0);
        #1;
        compared++;
        if ({code, code_valid, seq_err, err_count, interval_sec, timeout, state_dbg} !== 27'd0) begin
            mismatched++;
            $display("FAIL rst_async: code=%0d v=%0b err=%0b cnt=%0d int=%0d to=%0b st=%0d, expected all 0",
                     code, code_valid, seq_err, err_count, interval_sec, timeout, state_dbg);
        end
        tick();
        rst = 1'b0;
        valid_total = 0;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (code_valid) valid_total++;
            compared++;
            if (state_dbg !== 2'd0 || timeout !== 1'b0 || code !== 4'd0) begin
                mismatched++;
                $display("FAIL rst_init edge %0d: st=%0d to=%0b code=%0d, expected 0 0 0", k, state_dbg, timeout, code);
            end
        end
        compared++;
        if (valid_total !== 0) begin
            mismatched++;
            $display("FAIL rst_stray_valid: got %0d pulses, expected 0", valid_total);
        end
    endtask

    initial begin
        test_reset();
        test_first_code();
        test_sequence();
        test_glitch();
        test_seq_err();
        test_timeout();
        test_reset_mid_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
